// File: rtl/ext_ahb_ram.sv
// AHB-Lite slave model of the off-chip memory: word-organised RAM with
// configurable wait states and a two-cycle ERROR response outside its window.
module ext_ahb_ram #(
    parameter int              PA_BITS     = 56,
    parameter int              AHBW        = 64,
    parameter logic [63:0]     BASE        = 64'h8000_0000,
    parameter int              DEPTH       = 4096,
    parameter int              WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 HSELEXT,
    input  logic [PA_BITS-1:0]   HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic                 HREADY,
    input  logic [AHBW-1:0]      HWDATA,
    input  logic [AHBW/8-1:0]    HWSTRB,
    output logic [AHBW-1:0]      HRDATAEXT,
    output logic                 HREADYEXT,
    output logic                 HRESPEXT
);

    localparam int BYTES    = AHBW / 8;
    localparam int OFF_BITS = $clog2(BYTES);
    localparam int IDX_BITS = $clog2(DEPTH);
    localparam logic [PA_BITS-1:0] BASE_PA = BASE[PA_BITS-1:0];
    localparam logic [PA_BITS-1:0] SPAN    = PA_BITS'(DEPTH) * PA_BITS'(BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [IDX_BITS-1:0]   r_index;
    logic                  r_hready;
    logic                  r_hresp;
    logic [AHBW-1:0]       r_mem [DEPTH];

    logic [PA_BITS-1:0]    w_offset;
    logic                  w_in_range;
    logic [IDX_BITS-1:0]   w_index;
    logic                  w_accept;
    logic                  w_unused;

    assign w_offset   = HADDR - BASE_PA;
    assign w_in_range = (w_offset < SPAN);
    assign w_index    = w_offset[OFF_BITS +: IDX_BITS];
    // Only IDLE and DATA may open a new address phase; ERR2 deliberately refuses.
    assign w_accept   = HSELEXT & HREADY & HTRANS[1] &
                        ((r_state == ST_IDLE) || (r_state == ST_DATA));
    assign w_unused   = ^{HSIZE, HTRANS[0], w_offset};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_index  <= '0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DATA: begin
                    if (w_accept) begin
                        r_write <= HWRITE;
                        r_index <= w_index;
                        if (!w_in_range) begin
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            r_state  <= ST_WAIT;
                            r_cnt    <= 4'(WAIT_STATES - 1);
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                        end else begin
                            r_state  <= ST_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= ST_DATA;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                ST_ERR2: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset, and a reset
    // branch would also prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == ST_DATA) && r_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (HWSTRB[i]) r_mem[r_index][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATAEXT = ((r_state == ST_DATA) && !r_write) ? r_mem[r_index] : '0;
    assign HREADYEXT = r_hready;
    assign HRESPEXT  = r_hresp;

endmodule

// File: tb/tb_ext_ahb_ram.sv
// Directed bench for ext_ahb_ram: three instances with 2, 0 and 4 wait states
// share the bus signals; each has its own select and the bus HREADY follows the active one.
module tb_ext_ahb_ram;

    localparam logic [55:0] BASE_A = 56'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [55:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [63:0] hwdata;
    logic [7:0]  hwstrb;
    logic        sel [3];
    logic [63:0] hrdata [3];
    logic        hreadyext [3];
    logic        hrespext [3];
    logic [1:0]  active;
    logic        hready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    assign hready = hreadyext[active];

    ext_ahb_ram #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(reset), .HSELEXT(sel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATAEXT(hrdata[0]), .HREADYEXT(hreadyext[0]), .HRESPEXT(hrespext[0]));

    ext_ahb_ram #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .HSELEXT(sel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATAEXT(hrdata[1]), .HREADYEXT(hreadyext[1]), .HRESPEXT(hrespext[1]));

    ext_ahb_ram #(.WAIT_STATES(4)) u_ws4 (
        .clk(clk), .reset(reset), .HSELEXT(sel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
        .HRDATAEXT(hrdata[2]), .HREADYEXT(hreadyext[2]), .HRESPEXT(hrespext[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // One transfer on the active instance; returns completion-cycle data,
    // number of HREADYEXT-low cycles, and HRESPEXT in the first and last data-phase cycles.
    task automatic xfer(input logic wr, input logic [55:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb, output logic [63:0] rdata, output int waits,
                        output logic resp_first, output logic resp_last);
        logic done;
        @(posedge clk); #1;
        sel[active] = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr;
        @(posedge clk); #1;
        sel[active] = 1'b0; htrans = 2'b00; hwdata = wdata; hwstrb = strb;
        waits = 0; done = 1'b0; rdata = '0; resp_first = 1'b0; resp_last = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) resp_first = hrespext[active];
            if (hreadyext[active]) begin
                done = 1'b1; rdata = hrdata[active]; resp_last = hrespext[active];
            end else begin
                waits++;
                if (!wr) check("rdata_zero_in_wait", hrdata[active], 64'h0);
            end
        end
        check("xfer_completed", {63'h0, done}, 64'h1);
    endtask

    logic [63:0] rd;
    int          w;
    logic        rf, rl;

    initial begin
        reset = 1'b1; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd3;
        hwdata = '0; hwstrb = '0; active = 2'd0;
        for (int i = 0; i < 3; i++) sel[i] = 1'b0;

        // Reset values during three reset cycles and the first cycle after.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hready", {63'h0, hreadyext[0]}, 64'h1);
            check("rst_hresp",  {63'h0, hrespext[0]},  64'h0);
            check("rst_hrdata", hrdata[0], 64'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_hready", {63'h0, hreadyext[0]}, 64'h1);
        check("post_rst_hresp",  {63'h0, hrespext[0]},  64'h0);
        check("post_rst_hrdata", hrdata[0], 64'h0);

        // Round trip with two wait states.
        xfer(1'b1, BASE_A + 56'd8, 64'hDEADBEEF_CAFEF00D, 8'hFF, rd, w, rf, rl);
        check("wr_waits", 64'(w), 64'd2);
        check("wr_resp",  {63'h0, rl}, 64'h0);
        check("wr_rdata_zero", rd, 64'h0);
        xfer(1'b0, BASE_A + 56'd8, 64'h0, 8'h00, rd, w, rf, rl);
        check("rd_waits", 64'(w), 64'd2);
        check("rd_data",  rd, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        check("rd_data_after", hrdata[0], 64'h0);

        // Byte strobes on word 0.
        xfer(1'b1, BASE_A, 64'h0, 8'hFF, rd, w, rf, rl);
        xfer(1'b1, BASE_A, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, w, rf, rl);
        xfer(1'b0, BASE_A, 64'h0, 8'h00, rd, w, rf, rl);
        check("strb_data", rd, 64'h0000_0000_FFFF_FFFF);

        // Out of range: first address past the window aliases word 0 if truncated.
        xfer(1'b1, BASE_A + 56'd32768, 64'h1111_2222_3333_4444, 8'hFF, rd, w, rf, rl);
        check("err_waits", 64'(w), 64'd1);
        check("err1_resp", {63'h0, rf}, 64'h1);
        check("err2_resp", {63'h0, rl}, 64'h1);
        @(negedge clk);
        check("err_idle_hready", {63'h0, hreadyext[0]}, 64'h1);
        check("err_idle_hresp",  {63'h0, hrespext[0]},  64'h0);
        xfer(1'b0, BASE_A, 64'h0, 8'h00, rd, w, rf, rl);
        check("err_ram_unchanged", rd, 64'h0000_0000_FFFF_FFFF);
        xfer(1'b0, BASE_A - 56'd8, 64'h0, 8'h00, rd, w, rf, rl);
        check("below_base_resp", {63'h0, rl}, 64'h1);

        // Pipelined write then read of word 3, zero wait states.
        active = 2'd1;
        @(posedge clk); #1;
        sel[1] = 1'b1; haddr = BASE_A + 56'd24; htrans = 2'b10; hwrite = 1'b1;
        @(negedge clk);
        check("pipe_addr_hready", {63'h0, hreadyext[1]}, 64'h1);
        @(posedge clk); #1;
        hwdata = 64'h1234; hwstrb = 8'hFF; hwrite = 1'b0;
        @(negedge clk);
        check("pipe_wr_hready", {63'h0, hreadyext[1]}, 64'h1);
        check("pipe_wr_rdata",  hrdata[1], 64'h0);
        @(posedge clk); #1;
        sel[1] = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("pipe_rd_hready", {63'h0, hreadyext[1]}, 64'h1);
        check("pipe_rd_data",   hrdata[1], 64'h1234);
        @(negedge clk);
        check("pipe_idle_rdata", hrdata[1], 64'h0);

        // Reset during the second wait cycle abandons the write.
        active = 2'd2;
        xfer(1'b1, BASE_A + 56'd40, 64'h55, 8'hFF, rd, w, rf, rl);
        check("ws4_waits", 64'(w), 64'd4);
        @(posedge clk); #1;
        sel[2] = 1'b1; haddr = BASE_A + 56'd40; htrans = 2'b10; hwrite = 1'b1;
        @(posedge clk); #1;
        sel[2] = 1'b0; htrans = 2'b00; hwdata = 64'hAA; hwstrb = 8'hFF;
        @(negedge clk);
        check("ws4_wait1_hready", {63'h0, hreadyext[2]}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_hready", {63'h0, hreadyext[2]}, 64'h1);
        check("mid_rst_hresp",  {63'h0, hrespext[2]},  64'h0);
        xfer(1'b0, BASE_A + 56'd40, 64'h0, 8'h00, rd, w, rf, rl);
        check("mid_rst_data", rd, 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
